// File: rtl/lenet5_sequencer.sv
// lenet5_sequencer
// Top-level controller for the LeNet-5 accelerator core. It loads the weights
// and FC biases once from a read-only memory, then streams a programmable number
// of images. Between images it pulses the core's process-end reset and collects
// one classification result per image.
module lenet5_sequencer #(
    parameter int W_BW      = 8,
    parameter int B_BW      = 16,
    parameter int I_BW      = 8,
    parameter int M_BW      = 16,
    parameter int A_BW      = 20,
    parameter int W_COUNT   = 3220,
    parameter int B_COUNT   = 10,
    parameter int PIX_COUNT = 1024,
    parameter int N_BW      = 8,
    parameter int TIMEOUT   = 65535
) (
    input  logic            clk,
    input  logic            global_rst,
    input  logic            i_start,
    input  logic [N_BW-1:0] i_num_images,
    output logic            o_mem_rd,
    output logic [A_BW-1:0] o_mem_addr,
    input  logic [M_BW-1:0] i_mem_data,
    output logic            o_ce,
    output logic [W_BW-1:0] o_weight,
    output logic [B_BW-1:0] o_bias,
    output logic [I_BW-1:0] o_fmap,
    output logic            o_rst_processEnd,
    input  logic            i_cls_en,
    input  logic [3:0]      i_cls_result,
    input  logic            i_cls_end,
    output logic [3:0]      o_result,
    output logic            o_result_valid,
    output logic [N_BW-1:0] o_img_idx,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_timeout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_W   = 3'd1;
    localparam logic [2:0] ST_LOAD_B   = 3'd2;
    localparam logic [2:0] ST_STREAM   = 3'd3;
    localparam logic [2:0] ST_WAIT_RES = 3'd4;
    localparam logic [2:0] ST_NEXT     = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    // One phase counter serves all three load phases, so size it for the longest.
    localparam int CNT_MAX_WB = (W_COUNT > B_COUNT) ? W_COUNT : B_COUNT;
    localparam int CNT_MAX    = (CNT_MAX_WB > PIX_COUNT) ? CNT_MAX_WB : PIX_COUNT;
    localparam int CNT_BW     = $clog2(CNT_MAX + 1);
    localparam int WD_BW      = $clog2(TIMEOUT + 1);

    localparam logic [CNT_BW-1:0] W_LAST   = CNT_BW'(W_COUNT - 1);
    localparam logic [CNT_BW-1:0] B_LAST   = CNT_BW'(B_COUNT - 1);
    localparam logic [CNT_BW-1:0] P_LAST   = CNT_BW'(PIX_COUNT - 1);
    localparam logic [CNT_BW-1:0] CNT_ZERO = {CNT_BW{1'b0}};
    localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);
    localparam logic [WD_BW-1:0]  WD_LAST  = WD_BW'(TIMEOUT - 1);
    localparam logic [WD_BW-1:0]  WD_ZERO  = {WD_BW{1'b0}};
    localparam logic [WD_BW-1:0]  WD_ONE   = WD_BW'(1);
    localparam logic [A_BW-1:0]   ADDR_ZERO = {A_BW{1'b0}};
    localparam logic [A_BW-1:0]   ADDR_ONE  = A_BW'(1);
    localparam logic [N_BW-1:0]   IMG_ZERO  = {N_BW{1'b0}};
    localparam logic [N_BW-1:0]   IMG_ONE   = N_BW'(1);

    // Control state
    logic [2:0]        state_r, state_s;
    logic [CNT_BW-1:0] cnt_r, cnt_s;
    logic [WD_BW-1:0]  wd_r, wd_s;
    logic [N_BW-1:0]   img_r, img_s;
    logic [N_BW-1:0]   num_r, num_s;
    logic              rd_r, rd_s;
    logic [A_BW-1:0]   addr_r, addr_s;
    logic              rst_pe_r, rst_pe_s;
    logic              done_r, done_s;
    logic              timeout_r, timeout_s;
    logic              busy_r;
    logic              more_imgs_s;

    // Data path and result capture
    logic              rd_d1_r;
    logic              ce_r;
    logic [W_BW-1:0]   weight_r;
    logic [B_BW-1:0]   bias_r;
    logic [I_BW-1:0]   fmap_r;
    logic [3:0]        result_r;
    logic              result_valid_r;
    logic [N_BW-1:0]   img_idx_r;

    // True while at least one more image remains after the current one.
    assign more_imgs_s = ({1'b0, img_r} + {IMG_ZERO, 1'b1}) < {1'b0, num_r};

    // Next-state logic: every registered control output is computed one cycle ahead.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        wd_s      = wd_r;
        img_s     = img_r;
        num_s     = num_r;
        rd_s      = 1'b0;
        addr_s    = addr_r;
        rst_pe_s  = 1'b0;
        done_s    = 1'b0;
        timeout_s = timeout_r;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_s   = ST_LOAD_W;
                    num_s     = (i_num_images == IMG_ZERO) ? IMG_ONE : i_num_images;
                    timeout_s = 1'b0;
                    img_s     = IMG_ZERO;
                    cnt_s     = CNT_ZERO;
                    rd_s      = 1'b1;
                    addr_s    = ADDR_ZERO;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_LOAD_W: begin
                // Weights are followed directly by biases, so reads never pause.
                rd_s   = 1'b1;
                addr_s = addr_r + ADDR_ONE;
                if (cnt_r == W_LAST) begin
                    state_s = ST_LOAD_B;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_LOAD_B: begin
                // Image 0 starts right after the last bias, with no bubble.
                rd_s   = 1'b1;
                addr_s = addr_r + ADDR_ONE;
                if (cnt_r == B_LAST) begin
                    state_s = ST_STREAM;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_STREAM: begin
                if (cnt_r == P_LAST) begin
                    // Hold the last pixel address; the next image begins one word later.
                    state_s = ST_WAIT_RES;
                    wd_s    = WD_ZERO;
                    cnt_s   = CNT_ZERO;
                end else begin
                    rd_s    = 1'b1;
                    addr_s  = addr_r + ADDR_ONE;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_RES: begin
                if (i_cls_end) begin
                    state_s  = ST_NEXT;
                    rst_pe_s = 1'b1;
                end else if (wd_r == WD_LAST) begin
                    state_s   = ST_DONE;
                    timeout_s = 1'b1;
                    done_s    = 1'b1;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end
            ST_NEXT: begin
                if (more_imgs_s) begin
                    state_s = ST_STREAM;
                    img_s   = img_r + IMG_ONE;
                    cnt_s   = CNT_ZERO;
                    rd_s    = 1'b1;
                    addr_s  = addr_r + ADDR_ONE;
                end else begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: FSM, counters, read strobe/address and status pulses.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            wd_r      <= WD_ZERO;
            img_r     <= IMG_ZERO;
            num_r     <= IMG_ZERO;
            rd_r      <= 1'b0;
            addr_r    <= ADDR_ZERO;
            rst_pe_r  <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            wd_r      <= wd_s;
            img_r     <= img_s;
            num_r     <= num_s;
            rd_r      <= rd_s;
            addr_r    <= addr_s;
            rst_pe_r  <= rst_pe_s;
            done_r    <= done_s;
            timeout_r <= timeout_s;
            busy_r    <= (state_s != ST_IDLE);
        end
    end

    // Data path: memory answers one cycle after the strobe, then the word is registered.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            rd_d1_r  <= 1'b0;
            ce_r     <= 1'b0;
            weight_r <= {W_BW{1'b0}};
            bias_r   <= {B_BW{1'b0}};
            fmap_r   <= {I_BW{1'b0}};
        end else begin
            rd_d1_r <= rd_r;
            ce_r    <= rd_d1_r;
            if (rd_d1_r) begin
                weight_r <= i_mem_data[W_BW-1:0];
                bias_r   <= i_mem_data[B_BW-1:0];
                fmap_r   <= i_mem_data[I_BW-1:0];
            end else begin
                weight_r <= weight_r;
                bias_r   <= bias_r;
                fmap_r   <= fmap_r;
            end
        end
    end

    // Result capture: only while an image is in flight, tagged with its index.
    always_ff @(posedge clk or posedge global_rst) begin
        if (global_rst) begin
            result_r       <= 4'd0;
            result_valid_r <= 1'b0;
            img_idx_r      <= IMG_ZERO;
        end else if (i_cls_en && ((state_r == ST_STREAM) || (state_r == ST_WAIT_RES))) begin
            result_r       <= i_cls_result;
            result_valid_r <= 1'b1;
            img_idx_r      <= img_r;
        end else begin
            result_valid_r <= 1'b0;
        end
    end

    assign o_mem_rd         = rd_r;
    assign o_mem_addr       = addr_r;
    assign o_ce             = ce_r;
    assign o_weight         = weight_r;
    assign o_bias           = bias_r;
    assign o_fmap           = fmap_r;
    assign o_rst_processEnd = rst_pe_r;
    assign o_result         = result_r;
    assign o_result_valid   = result_valid_r;
    assign o_img_idx        = img_idx_r;
    assign o_busy           = busy_r;
    assign o_done           = done_r;
    assign o_timeout        = timeout_r;

endmodule

// File: tb/tb_lenet5_sequencer.sv
// Directed bench for lenet5_sequencer with a small memory (word = address)
// and a core model that answers a fixed number of cycles after each image.
module tb_lenet5_sequencer;

    localparam int W_BW = 8, B_BW = 16, I_BW = 8, M_BW = 16, A_BW = 20;
    localparam int W_COUNT = 4, B_COUNT = 2, PIX_COUNT = 3, N_BW = 8, TIMEOUT = 20;

    logic            clk = 1'b0;
    logic            global_rst;
    logic            i_start;
    logic [N_BW-1:0] i_num_images;
    logic            o_mem_rd;
    logic [A_BW-1:0] o_mem_addr;
    logic [M_BW-1:0] i_mem_data;
    logic            o_ce;
    logic [W_BW-1:0] o_weight;
    logic [B_BW-1:0] o_bias;
    logic [I_BW-1:0] o_fmap;
    logic            o_rst_processEnd;
    logic            i_cls_en;
    logic [3:0]      i_cls_result;
    logic            i_cls_end;
    logic [3:0]      o_result;
    logic            o_result_valid;
    logic [N_BW-1:0] o_img_idx;
    logic            o_busy;
    logic            o_done;
    logic            o_timeout;

    lenet5_sequencer #(
        .W_BW(W_BW), .B_BW(B_BW), .I_BW(I_BW), .M_BW(M_BW), .A_BW(A_BW),
        .W_COUNT(W_COUNT), .B_COUNT(B_COUNT), .PIX_COUNT(PIX_COUNT),
        .N_BW(N_BW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .global_rst(global_rst), .i_start(i_start), .i_num_images(i_num_images),
        .o_mem_rd(o_mem_rd), .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
        .o_ce(o_ce), .o_weight(o_weight), .o_bias(o_bias), .o_fmap(o_fmap),
        .o_rst_processEnd(o_rst_processEnd), .i_cls_en(i_cls_en),
        .i_cls_result(i_cls_result), .i_cls_end(i_cls_end), .o_result(o_result),
        .o_result_valid(o_result_valid), .o_img_idx(o_img_idx), .o_busy(o_busy),
        .o_done(o_done), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int num_checks = 0;
    int num_errors = 0;
    int cyc, run_s;
    int ce_cnt, core_t, core_img, en_dly, end_dly;
    int prev_rd, prev_addr, prev_to, prev_busy;
    int to_c, busy_rise, busy_fall, to_first;
    int rd_a[$], rd_c[$], ce_w[$], ce_b[$], ce_f[$], ce_c[$];
    int rpe_c[$], done_c[$], res_v[$], res_i[$], res_c[$];

    task automatic check_val(input string tag, input int act, input int exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_a.delete(); rd_c.delete(); ce_w.delete(); ce_b.delete(); ce_f.delete();
        ce_c.delete(); rpe_c.delete(); done_c.delete(); res_v.delete(); res_i.delete();
        res_c.delete();
        to_c = -1; busy_rise = -1; busy_fall = -1;
        ce_cnt = 0; core_t = -1; core_img = 0;
    endtask

    // One clock: memory model, logging of outputs, then core model drive.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        i_mem_data = (prev_rd != 0) ? M_BW'(prev_addr) : M_BW'(32'hDEAD);
        prev_rd   = int'(o_mem_rd);
        prev_addr = int'(o_mem_addr);
        if (o_mem_rd) begin
            rd_a.push_back(int'(o_mem_addr)); rd_c.push_back(cyc);
        end
        if (o_ce) begin
            ce_w.push_back(int'(o_weight)); ce_b.push_back(int'(o_bias));
            ce_f.push_back(int'(o_fmap));   ce_c.push_back(cyc);
            ce_cnt++;
        end
        if (o_rst_processEnd) rpe_c.push_back(cyc);
        if (o_done) done_c.push_back(cyc);
        if (o_result_valid) begin
            res_v.push_back(int'(o_result)); res_i.push_back(int'(o_img_idx));
            res_c.push_back(cyc);
        end
        if (o_timeout && prev_to == 0 && to_c < 0) to_c = cyc;
        if (o_busy && prev_busy == 0 && busy_rise < 0) busy_rise = cyc;
        if (!o_busy && prev_busy != 0 && busy_fall < 0) busy_fall = cyc;
        prev_to   = int'(o_timeout);
        prev_busy = int'(o_busy);
        i_cls_en  = 1'b0;
        i_cls_end = 1'b0;
        if (core_t >= 0) core_t++;
        if (o_ce && ce_cnt > W_COUNT + B_COUNT &&
            ((ce_cnt - W_COUNT - B_COUNT) % PIX_COUNT) == 0) core_t = 0;
        if (core_t >= 0 && core_t == en_dly) begin
            i_cls_en = 1'b1; i_cls_result = 4'(core_img + 7);
        end
        if (core_t >= 0 && core_t == end_dly) begin
            i_cls_end = 1'b1; core_img++; core_t = -1;
        end
    endtask

    task automatic run(input int n_in, input int extra_rel);
        clear_logs();
        i_num_images = N_BW'(n_in);
        i_start = 1'b1;
        run_s = cyc;
        step();
        i_start = 1'b0;
        to_first = int'(o_timeout);
        for (int k = 0; k < 300 && done_c.size() == 0; k++) begin
            i_start = (extra_rel > 0 && cyc == run_s + extra_rel) ? 1'b1 : 1'b0;
            step();
        end
        i_start = 1'b0;
        check_val("run_done_seen", int'(done_c.size() > 0), 1);
        repeat (3) step();
    endtask

    // Expected schedule for a completed run with the core ending 5 cycles after each image.
    task automatic check_run(input int n, input int en_d);
        int s, ec, nr;
        s  = run_s;
        nr = W_COUNT + B_COUNT + PIX_COUNT * n;
        check_val("rd_count", rd_a.size(), nr);
        for (int i = 0; i < rd_a.size() && i < nr; i++) begin
            ec = (i < 6) ? s + 1 + i : s + 7 + 11 * ((i - 6) / 3) + (i - 6) % 3;
            check_val($sformatf("rd_addr[%0d]", i), rd_a[i], i);
            check_val($sformatf("rd_cyc[%0d]", i), rd_c[i], ec);
        end
        check_val("ce_count", ce_c.size(), nr);
        for (int i = 0; i < ce_c.size() && i < nr; i++) begin
            ec = (i < 6) ? s + 3 + i : s + 9 + 11 * ((i - 6) / 3) + (i - 6) % 3;
            check_val($sformatf("ce_cyc[%0d]", i), ce_c[i], ec);
            if (i < W_COUNT) check_val($sformatf("weight[%0d]", i), ce_w[i], i);
            else if (i < W_COUNT + B_COUNT) check_val($sformatf("bias[%0d]", i), ce_b[i], i);
            else check_val($sformatf("fmap[%0d]", i), ce_f[i], i);
        end
        check_val("rpe_count", rpe_c.size(), n);
        for (int k = 0; k < rpe_c.size() && k < n; k++)
            check_val($sformatf("rpe_cyc[%0d]", k), rpe_c[k], s + 17 + 11 * k);
        check_val("res_count", res_v.size(), n);
        for (int k = 0; k < res_v.size() && k < n; k++) begin
            check_val($sformatf("res_val[%0d]", k), res_v[k], (7 + k) % 16);
            check_val($sformatf("res_idx[%0d]", k), res_i[k], k);
            check_val($sformatf("res_cyc[%0d]", k), res_c[k], s + 12 + 11 * k + en_d);
        end
        check_val("done_count", done_c.size(), 1);
        if (done_c.size() > 0) begin
            check_val("done_cyc", done_c[0], s + 18 + 11 * (n - 1));
            check_val("busy_fall", busy_fall, done_c[0] + 1);
        end
        check_val("busy_rise", busy_rise, s + 1);
        check_val("timeout_rise", to_c, -1);
    endtask

    initial begin
        global_rst = 1'b1; i_start = 1'b0; i_num_images = '0; i_mem_data = '0;
        i_cls_en = 1'b0; i_cls_end = 1'b0; i_cls_result = 4'd0;
        cyc = 0; prev_rd = 0; prev_addr = 0; prev_to = 0; prev_busy = 0;
        en_dly = 3; end_dly = 5;
        clear_logs();
        repeat (2) step();
        check_val("rst_mem_rd", int'(o_mem_rd), 0);
        check_val("rst_addr", int'(o_mem_addr), 0);
        check_val("rst_busy", int'(o_busy), 0);
        check_val("rst_others", int'(|{o_ce, o_weight, o_bias, o_fmap, o_rst_processEnd,
                  o_result, o_result_valid, o_img_idx, o_done, o_timeout}), 0);
        global_rst = 1'b0;
        step();

        // Single image, result strobe before end
        run(1, 0);
        check_run(1, 3);

        // Three images: weights/biases once, indices 0..2
        run(3, 0);
        check_run(3, 3);

        // Core never ends: watchdog expires
        en_dly = -1; end_dly = -1;
        run(2, 0);
        check_val("to_rise_cyc", to_c, run_s + 10 + TIMEOUT);
        check_val("to_done_count", done_c.size(), 1);
        if (done_c.size() > 0) check_val("to_done_cyc", done_c[0], run_s + 10 + TIMEOUT);
        check_val("to_rd_count", rd_a.size(), 9);
        check_val("to_rpe_count", rpe_c.size(), 0);
        check_val("to_res_count", res_v.size(), 0);
        check_val("to_sticky", int'(o_timeout), 1);
        en_dly = 3; end_dly = 5;
        run(1, 0);
        check_val("to_cleared", to_first, 0);
        check_run(1, 3);

        // Start pulse while in LOAD_B is ignored
        run(1, 5);
        check_run(1, 3);

        // Zero images behaves as one
        run(0, 0);
        check_run(1, 3);

        // Result strobe and end in the same cycle
        en_dly = 5;
        run(2, 0);
        check_run(2, 5);
        en_dly = 3;

        // Reset in the middle of image 1
        clear_logs();
        i_num_images = N_BW'(3);
        i_start = 1'b1;
        run_s = cyc;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 100 && cyc < run_s + 19; k++) step();
        check_val("pre_rst_rd", int'(o_mem_rd), 1);
        check_val("pre_rst_addr", int'(o_mem_addr), 10);
        #2;
        global_rst = 1'b1;
        #1;
        check_val("arst_mem_rd", int'(o_mem_rd), 0);
        check_val("arst_addr", int'(o_mem_addr), 0);
        check_val("arst_busy", int'(o_busy), 0);
        check_val("arst_result", int'(o_result), 0);
        check_val("arst_others", int'(|{o_ce, o_weight, o_bias, o_fmap, o_rst_processEnd,
                  o_result_valid, o_img_idx, o_done, o_timeout}), 0);
        clear_logs();
        repeat (3) step();
        global_rst = 1'b0;
        repeat (5) step();
        check_val("post_rst_done", done_c.size(), 0);
        check_val("post_rst_rpe", rpe_c.size(), 0);
        check_val("post_rst_rd", rd_a.size(), 0);
        run(1, 0);
        check_run(1, 3);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
